// File: rtl/msgPass_config_pkg.sv
// Shared configuration for the message-passing buffer address generator.
// Combinational definitions only (no latency, no flow control).
package msgPass_config_pkg;

    localparam int MSGPASS_BUFF_ADDR_WIDTH    = 7;
    localparam int MSGPASS_ADDR_GEN_CNT_WIDTH = 8;
    localparam int INCREMENT_SRC_NUM          = 3;
    localparam int INCREMENT_SRC_SEL_WIDTH    = $clog2(INCREMENT_SRC_NUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } msgPass_addr_gen_state_e;

    typedef enum logic [INCREMENT_SRC_SEL_WIDTH-1:0] {
        INC_ONE    = 0,
        INC_STRIDE = 1,
        INC_SHIFT  = 2
    } inc_src_e;

endpackage

// File: rtl/msgPass_addr_inc.sv
// Increment source mux plus (ADDR_WIDTH+1)-bit adder: next address and carry.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module msgPass_addr_inc
    import msgPass_config_pkg::*;
#(
    parameter int          ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int unsigned SRC_NUM    = INCREMENT_SRC_NUM
) (
    input  logic [ADDR_WIDTH-1:0]              addr_i,
    input  logic [INCREMENT_SRC_SEL_WIDTH-1:0] sel_i,
    input  logic [ADDR_WIDTH-1:0]              stride_i,
    input  logic [ADDR_WIDTH-1:0]              shift_i,
    output logic [ADDR_WIDTH-1:0]              next_addr_o,
    output logic                               carry_o
);

    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH:0]   sum;

    // Codes at or beyond SRC_NUM fall back to a unit step.
    always_comb begin
        inc = ADDR_WIDTH'(1);
        if (32'(sel_i) < SRC_NUM) begin
            case (sel_i)
                INC_STRIDE: inc = stride_i;
                INC_SHIFT:  inc = shift_i;
                default:    inc = ADDR_WIDTH'(1);
            endcase
        end
    end

    assign sum         = {1'b0, addr_i} + {1'b0, inc};
    assign next_addr_o = sum[ADDR_WIDTH-1:0];
    assign carry_o     = sum[ADDR_WIDTH];

endmodule

// File: rtl/msgpass_addr_gen.sv
// Burst address generator for the message-passing buffer; wrap_o only with MSGPASS_ADDR_GEN_WRAP_CHK_EN.
// Latency: first address one cycle after an accepted start, then one per handshake; done one cycle after the last.
// Backpressure: addr_o/last_o hold while addr_valid_o is high and addr_ready_i is low; start ignored while busy.
module msgpass_addr_gen
    import msgPass_config_pkg::*;
#(
    parameter int          ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int          CNT_WIDTH  = MSGPASS_ADDR_GEN_CNT_WIDTH,
    parameter int unsigned SRC_NUM    = INCREMENT_SRC_NUM
) (
    input  logic                               sys_clk,
    input  logic                               rstn,
    input  logic                               start_i,
    input  logic [ADDR_WIDTH-1:0]              base_addr_i,
    input  logic [CNT_WIDTH-1:0]               burst_len_i,
    input  logic [INCREMENT_SRC_SEL_WIDTH-1:0] inc_src_sel_i,
    input  logic [ADDR_WIDTH-1:0]              stride_i,
    input  logic [ADDR_WIDTH-1:0]              shift_i,
    input  logic                               addr_ready_i,
    output logic [ADDR_WIDTH-1:0]              addr_o,
    output logic                               addr_valid_o,
    output logic                               last_o,
    output logic                               busy_o,
    output logic                               done_o
`ifdef MSGPASS_ADDR_GEN_WRAP_CHK_EN
    ,
    output logic                               wrap_o
`endif
);

    msgPass_addr_gen_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
    logic [CNT_WIDTH-1:0]               rem_q, rem_d;
    logic [INCREMENT_SRC_SEL_WIDTH-1:0] sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]              stride_q, stride_d;
    logic valid_q, valid_d;
    logic last_q, last_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic                  hs;
    logic                  start_acc;
    logic                  step;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  inc_carry;

    msgPass_addr_inc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SRC_NUM    (SRC_NUM)
    ) u_inc (
        .addr_i      (addr_q),
        .sel_i       (sel_q),
        .stride_i    (stride_q),
        .shift_i     (shift_i),
        .next_addr_o (next_addr),
        .carry_o     (inc_carry)
    );

    assign hs = valid_q & addr_ready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        sel_d     = sel_q;
        stride_d  = stride_q;
        start_acc = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    addr_d    = base_addr_i;
                    rem_d     = burst_len_i;
                    sel_d     = inc_src_sel_i;
                    stride_d  = stride_i;
                    state_d   = (burst_len_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    if (rem_q == CNT_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        step   = 1'b1;
                        addr_d = next_addr;
                        rem_d  = rem_q - CNT_WIDTH'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Output flops are loaded from the next state so every output is a register.
        valid_d = (state_d == ISSUE);
        last_d  = valid_d && (rem_d == CNT_WIDTH'(1));
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            sel_q    <= '0;
            stride_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            sel_q    <= sel_d;
            stride_q <= stride_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = valid_q;
    assign last_o       = last_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

`ifdef MSGPASS_ADDR_GEN_WRAP_CHK_EN
    logic wrap_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            wrap_q <= 1'b0;
        end else if (start_acc) begin
            wrap_q <= 1'b0;
        end else if (step && inc_carry) begin
            wrap_q <= 1'b1;
        end
    end

    assign wrap_o = wrap_q;
`else
    logic wrap_unused;
    assign wrap_unused = start_acc & step & inc_carry;
`endif

endmodule

// File: tb/tb_msgpass_addr_gen.sv
// Scoreboard bench for msgpass_addr_gen; wrap_o checks compile in with MSGPASS_ADDR_GEN_WRAP_CHK_EN.
module tb_msgpass_addr_gen;

    logic       clk;
    logic       rstn;
    logic       start_i;
    logic [6:0] base_addr_i;
    logic [7:0] burst_len_i;
    logic [1:0] inc_src_sel_i;
    logic [6:0] stride_i;
    logic [6:0] shift_i;
    logic       addr_ready_i;
    logic [6:0] addr_o;
    logic       addr_valid_o;
    logic       last_o;
    logic       busy_o;
    logic       done_o;
`ifdef MSGPASS_ADDR_GEN_WRAP_CHK_EN
    logic       wrap_o;
`endif

    typedef struct packed {
        logic [6:0] addr;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    msgpass_addr_gen dut (
        .sys_clk       (clk),
        .rstn          (rstn),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .burst_len_i   (burst_len_i),
        .inc_src_sel_i (inc_src_sel_i),
        .stride_i      (stride_i),
        .shift_i       (shift_i),
        .addr_ready_i  (addr_ready_i),
        .addr_o        (addr_o),
        .addr_valid_o  (addr_valid_o),
        .last_o        (last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
`ifdef MSGPASS_ADDR_GEN_WRAP_CHK_EN
        ,
        .wrap_o        (wrap_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Pushes the model stream (sel 2 streams are pushed by the caller), then pulses start for one cycle.
    task automatic launch(input logic [6:0] base, input logic [7:0] len, input logic [1:0] sel,
                          input logic [6:0] stride, input bit model);
        logic [6:0] a;
        a = base;
        if (model) begin
            for (int i = 0; i < int'(len); i++) begin
                sb.push_back(exp_t'{a, (i == int'(len) - 1)});
                a = a + ((sel == 2'd1) ? stride : 7'd1);
            end
        end
        base_addr_i   = base;
        burst_len_i   = len;
        inc_src_sel_i = sel;
        stride_i      = stride;
        start_i       = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int exp_cyc, input bit rnd);
        int c;
        c = c0;
        while (!done_o && c < 400) begin
            if (rnd) addr_ready_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            c++;
        end
        addr_ready_i = 1'b1;
        chk("done_seen", 32'(done_o), 32'd1);
        if (exp_cyc > 0) chk("done_cycle", 32'(c), 32'(exp_cyc));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done_o), 32'd0);
        chk("idle_after_done", 32'(busy_o), 32'd0);
    endtask

    // Monitor: pops on every handshake and checks stability across stalls.
    initial begin
        bit         stall;
        logic [6:0] hold_addr;
        logic       hold_last;
        exp_t       e;
        stall = 1'b0;
        hold_addr = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_vld", 32'(addr_valid_o), 32'd1);
                    chk("hold_addr", 32'(addr_o), 32'(hold_addr));
                    chk("hold_last", 32'(last_o), 32'(hold_last));
                end
                if (addr_valid_o && addr_ready_i) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_addr", 32'(addr_o), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("addr", 32'(addr_o), 32'(e.addr));
                        chk("last", 32'(last_o), 32'(e.last));
                    end
                end
                stall     = addr_valid_o && !addr_ready_i;
                hold_addr = addr_o;
                hold_last = last_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int c;
        rstn = 1'b0;
        start_i = 1'b0;
        base_addr_i = '0;
        burst_len_i = '0;
        inc_src_sel_i = '0;
        stride_i = '0;
        shift_i = '0;
        addr_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 32'(addr_o), 32'd0);
        chk("rst_vld", 32'(addr_valid_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
`ifdef MSGPASS_ADDR_GEN_WRAP_CHK_EN
        chk("rst_wrap", 32'(wrap_o), 32'd0);
`endif
        rstn = 1'b1;
        @(posedge clk); #1;

        // Sequential burst 5,6,7,8
        launch(7'd5, 8'd4, 2'd0, 7'd0, 1'b1);
        chk("seq_first_vld", 32'(addr_valid_o), 32'd1);
        chk("seq_first_busy", 32'(busy_o), 32'd1);
        chk("seq_first_addr", 32'(addr_o), 32'd5);
        wait_done(1, 5, 1'b0);

        // Stride with wrap 120,125,2
        launch(7'd120, 8'd3, 2'd1, 7'd5, 1'b1);
        wait_done(1, 4, 1'b0);
`ifdef MSGPASS_ADDR_GEN_WRAP_CHK_EN
        chk("wrap_set", 32'(wrap_o), 32'd1);
`endif

        // Unused select code steps by one: 126,127,0
        launch(7'd126, 8'd3, 2'd3, 7'd9, 1'b1);
`ifdef MSGPASS_ADDR_GEN_WRAP_CHK_EN
        chk("wrap_clr_on_start", 32'(wrap_o), 32'd0);
`endif
        wait_done(1, 4, 1'b0);

        // Live shift with backpressure: held at 10, then 17, 19
        sb.push_back(exp_t'{7'd10, 1'b0});
        sb.push_back(exp_t'{7'd17, 1'b0});
        sb.push_back(exp_t'{7'd19, 1'b1});
        addr_ready_i = 1'b0;
        launch(7'd10, 8'd3, 2'd2, 7'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_addr", 32'(addr_o), 32'd10);
            shift_i = 7'(i * 3 + 1);
            @(posedge clk); #1;
        end
        shift_i = 7'd7;
        addr_ready_i = 1'b1;
        @(posedge clk); #1;
        shift_i = 7'd2;
        @(posedge clk); #1;
        shift_i = 7'd0;
        wait_done(6, 7, 1'b0);

        // Zero length
        launch(7'd33, 8'd0, 2'd0, 7'd0, 1'b1);
        chk("zero_vld", 32'(addr_valid_o), 32'd0);
        chk("zero_busy", 32'(busy_o), 32'd1);
        wait_done(1, 1, 1'b0);

        // Starts during ISSUE and DONE are ignored
        launch(7'd40, 8'd4, 2'd0, 7'd0, 1'b1);
        base_addr_i = 7'd99;
        burst_len_i = 8'd2;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        c = 2;
        while (!done_o && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("ign_done_cycle", 32'(c), 32'd5);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("ign_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("ign_vld", 32'(addr_valid_o), 32'd0);
        end

        // Random backpressure, stride 3 with wrap
        launch(7'd100, 8'd10, 2'd1, 7'd3, 1'b1);
        wait_done(1, 0, 1'b1);

        // Reset mid-burst on the second address
        launch(7'd0, 8'd6, 2'd0, 7'd0, 1'b1);
        @(posedge clk); #1;
        chk("mid_second_addr", 32'(addr_o), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(addr_o), 32'd0);
        chk("mid_rst_vld", 32'(addr_valid_o), 32'd0);
        chk("mid_rst_last", 32'(last_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("in_rst_done", 32'(done_o), 32'd0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", 32'(done_o), 32'd0);
            chk("post_rst_vld", 32'(addr_valid_o), 32'd0);
        end
        launch(7'd3, 8'd2, 2'd0, 7'd0, 1'b1);
        wait_done(1, 3, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
